// File: rtl/tx_package_pkg.sv
// Shared definitions for the framed UART transmit path: byte width,
// payload buffer depth and the frame sequencer state encoding.
package tx_package_pkg;

  localparam int BYTE       = 8;
  localparam int FIFO_DEPTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SOF     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_EOF     = 2'd3
  } state_t;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous first-word-fall-through FIFO used as the payload buffer.
// A push while full and a pop while empty are ignored; a simultaneous
// push and pop both take effect and leave the count unchanged.
module tx_fifo #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_package.sv
// Frame builder in front of a UART transmitter: buffers payload bytes and,
// once a full frame is available, emits SOF pattern, payload (with an
// optional substituted window) and an optional EOF pattern.
module tx_package
  import tx_package_pkg::*;
#(
  parameter logic [15:0] SOFPATTERN = 16'hEB90,
  parameter bit          EOFENABLE  = 1'b1,
  parameter logic [15:0] EOFPATTERN = 16'h90EB,
  parameter int          FRAMECNT   = 64,
  parameter bit          SUB        = 1'b1,
  parameter int          SUBPOS     = 2,
  parameter int          SUBLENGTH  = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic                      payload_valid,
  input  logic [BYTE-1:0]           payload_data,
  output logic                      payload_ready,
  input  logic                      sub_data_valid,
  input  logic [SUBLENGTH*BYTE-1:0] sub_data,
  output logic [BYTE-1:0]           tx_data,
  output logic                      tx_data_valid,
  input  logic                      tx_ready,
  output logic                      frame_busy,
  output logic                      frame_done,
  output logic [10:0]               frame_count
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]  FRAME_LEN = CNT_W'(FRAMECNT);
  localparam logic [6:0]        LAST_IDX  = 7'(FRAMECNT - 1);

  state_t                    state;
  logic [6:0]                idx;
  logic [BYTE-1:0]           hdr_byte;
  logic [BYTE-1:0]           fifo_dout;
  logic [BYTE-1:0]           sub_byte;
  logic [SUBLENGTH*BYTE-1:0] pending_sub;
  logic [SUBLENGTH*BYTE-1:0] active_sub;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      accept;
  logic                      in_sub;

  assign payload_ready = !fifo_full;
  assign push          = payload_valid && payload_ready;
  assign accept        = tx_data_valid && tx_ready;
  // Every payload position consumes one buffered byte, substituted or not.
  assign pop           = accept && (state == ST_PAYLOAD) && !fifo_empty;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (payload_data),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Select the substitution byte for the current payload index, first byte in the MSBs.
  always_comb begin
    in_sub   = 1'b0;
    sub_byte = '0;
    for (int k = 0; k < SUBLENGTH; k++) begin
      if (SUB && (idx == 7'(SUBPOS + k))) begin
        in_sub   = 1'b1;
        sub_byte = active_sub[SUBLENGTH*BYTE-1-BYTE*k -: BYTE];
      end
    end
  end

  // Output byte: header/trailer register outside PAYLOAD, buffer head or substitution inside.
  always_comb begin
    tx_data = hdr_byte;
    if (state == ST_PAYLOAD) tx_data = in_sub ? sub_byte : fifo_dout;
  end

  // Substitution bytes may arrive at any time; they wait here until a frame starts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             pending_sub <= '0;
    else if (sub_data_valid) pending_sub <= sub_data;
  end

  // Frame sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      idx           <= '0;
      hdr_byte      <= '0;
      tx_data_valid <= 1'b0;
      frame_busy    <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
      active_sub    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && (fifo_count >= FRAME_LEN)) begin
            state         <= ST_SOF;
            idx           <= '0;
            hdr_byte      <= SOFPATTERN[15:8];
            tx_data_valid <= 1'b1;
            frame_busy    <= 1'b1;
            active_sub    <= pending_sub;
          end
        end
        ST_SOF: begin
          if (accept) begin
            if (idx == 7'd0) begin
              idx      <= 7'd1;
              hdr_byte <= SOFPATTERN[7:0];
            end else begin
              state    <= ST_PAYLOAD;
              idx      <= '0;
              hdr_byte <= '0;
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            if (idx != LAST_IDX) begin
              idx <= idx + 7'd1;
            end else if (EOFENABLE) begin
              state    <= ST_EOF;
              idx      <= '0;
              hdr_byte <= EOFPATTERN[15:8];
            end else begin
              state         <= ST_IDLE;
              idx           <= '0;
              hdr_byte      <= '0;
              tx_data_valid <= 1'b0;
              frame_busy    <= 1'b0;
              frame_done    <= 1'b1;
              frame_count   <= frame_count + 11'd1;
            end
          end
        end
        ST_EOF: begin
          if (accept) begin
            if (idx == 7'd0) begin
              idx      <= 7'd1;
              hdr_byte <= EOFPATTERN[7:0];
            end else begin
              state         <= ST_IDLE;
              idx           <= '0;
              hdr_byte      <= '0;
              tx_data_valid <= 1'b0;
              frame_busy    <= 1'b0;
              frame_done    <= 1'b1;
              frame_count   <= frame_count + 11'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_package.sv
// Bench for tx_package: instance A (FRAMECNT=4, no substitution) and
// instance B (FRAMECNT=6, substitution window at 2..3), sharing clock and reset.
module tb_tx_package;

  logic clk;
  logic resetn;

  logic        a_enable, a_pv, a_pr, a_sdv, a_txv, a_txr, a_busy, a_done;
  logic [7:0]  a_pd, a_txd;
  logic [63:0] a_sd;
  logic [10:0] a_fc;

  logic        b_enable, b_pv, b_pr, b_sdv, b_txv, b_txr, b_busy, b_done;
  logic [7:0]  b_pd, b_txd;
  logic [15:0] b_sd;
  logic [10:0] b_fc;

  int n_cmp;
  int n_fail;
  int a_fc_exp;

  tx_package #(.FRAMECNT(4), .SUB(1'b0)) u_a (
    .clk(clk), .resetn(resetn), .enable(a_enable),
    .payload_valid(a_pv), .payload_data(a_pd), .payload_ready(a_pr),
    .sub_data_valid(a_sdv), .sub_data(a_sd),
    .tx_data(a_txd), .tx_data_valid(a_txv), .tx_ready(a_txr),
    .frame_busy(a_busy), .frame_done(a_done), .frame_count(a_fc)
  );

  tx_package #(.FRAMECNT(6), .SUB(1'b1), .SUBPOS(2), .SUBLENGTH(2)) u_b (
    .clk(clk), .resetn(resetn), .enable(b_enable),
    .payload_valid(b_pv), .payload_data(b_pd), .payload_ready(b_pr),
    .sub_data_valid(b_sdv), .sub_data(b_sd),
    .tx_data(b_txd), .tx_data_valid(b_txv), .tx_ready(b_txr),
    .frame_busy(b_busy), .frame_done(b_done), .frame_count(b_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_a(input logic [7:0] v);
    @(posedge clk); #1;
    a_pv = 1'b1;
    a_pd = v;
  endtask

  task automatic push_b(input logic [7:0] v);
    @(posedge clk); #1;
    b_pv = 1'b1;
    b_pd = v;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #2;
    n_cmp += 12;
    if (a_txv !== 1'b0)  begin n_fail++; $display("FAIL rst_a_txv got %b want 0", a_txv); end
    if (a_txd !== 8'h00) begin n_fail++; $display("FAIL rst_a_txd got %h want 00", a_txd); end
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_a_busy got %b want 0", a_busy); end
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL rst_a_done got %b want 0", a_done); end
    if (a_fc !== 11'd0)  begin n_fail++; $display("FAIL rst_a_fc got %0d want 0", a_fc); end
    if (a_pr !== 1'b1)   begin n_fail++; $display("FAIL rst_a_ready got %b want 1", a_pr); end
    if (b_txv !== 1'b0)  begin n_fail++; $display("FAIL rst_b_txv got %b want 0", b_txv); end
    if (b_txd !== 8'h00) begin n_fail++; $display("FAIL rst_b_txd got %h want 00", b_txd); end
    if (b_busy !== 1'b0) begin n_fail++; $display("FAIL rst_b_busy got %b want 0", b_busy); end
    if (b_done !== 1'b0) begin n_fail++; $display("FAIL rst_b_done got %b want 0", b_done); end
    if (b_fc !== 11'd0)  begin n_fail++; $display("FAIL rst_b_fc got %0d want 0", b_fc); end
    if (b_pr !== 1'b1)   begin n_fail++; $display("FAIL rst_b_ready got %b want 1", b_pr); end
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_basic;
    logic [7:0] exp [8] = '{8'hEB, 8'h90, 8'h01, 8'h02, 8'h03, 8'h04, 8'h90, 8'hEB};
    int waited = 0;
    for (int i = 0; i < 4; i++) push_a(8'(i + 1));
    @(posedge clk); #1;
    a_pv = 1'b0; a_txr = 1'b1; a_enable = 1'b1;
    @(negedge clk);
    while (!a_txv && waited < 10) begin @(negedge clk); waited++; end
    n_cmp++;
    if (a_txv !== 1'b1) begin n_fail++; $display("FAIL basic_start got valid=%b want 1", a_txv); end
    if (a_busy !== 1'b1) begin n_cmp++; n_fail++; $display("FAIL basic_busy got %b want 1", a_busy); end
    else n_cmp++;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({a_txv, a_txd} !== {1'b1, exp[i]}) begin
        n_fail++;
        $display("FAIL basic_byte%0d got valid=%b data=%h want valid=1 data=%h", i, a_txv, a_txd, exp[i]);
      end
      @(negedge clk);
    end
    n_cmp += 3;
    if (a_done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", a_done); end
    if (a_fc !== 11'd1)  begin n_fail++; $display("FAIL basic_count got %0d want 1", a_fc); end
    if (a_txv !== 1'b0)  begin n_fail++; $display("FAIL basic_idle_valid got %b want 0", a_txv); end
    @(posedge clk); #1 a_enable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", a_done); end
    a_fc_exp = 1;
  endtask

  task automatic test_backpressure;
    logic [7:0] exp [8] = '{8'hEB, 8'h90, 8'h01, 8'h02, 8'h03, 8'h04, 8'h90, 8'hEB};
    int got = 0, dones = 0;
    logic held = 1'b0;
    logic [7:0] held_d = '0;
    for (int i = 0; i < 4; i++) push_a(8'(i + 1));
    @(posedge clk); #1;
    a_pv = 1'b0; a_enable = 1'b1; a_txr = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      a_txr = (c % 2 == 0);
      if (got >= 1) a_enable = 1'b0;
      @(negedge clk);
      if (held) begin
        n_cmp++;
        if ({a_txv, a_txd} !== {1'b1, held_d}) begin
          n_fail++;
          $display("FAIL bp_stable got valid=%b data=%h want valid=1 data=%h", a_txv, a_txd, held_d);
        end
      end
      held   = a_txv && !a_txr;
      held_d = a_txd;
      if (a_txv && a_txr) begin
        if (got < 8) begin
          n_cmp++;
          if (a_txd !== exp[got]) begin
            n_fail++;
            $display("FAIL bp_byte%0d got %h want %h", got, a_txd, exp[got]);
          end
        end
        got++;
      end
      if (a_done) dones++;
    end
    a_fc_exp++;
    n_cmp += 3;
    if (got != 8)   begin n_fail++; $display("FAIL bp_len got %0d want 8", got); end
    if (dones != 1) begin n_fail++; $display("FAIL bp_dones got %0d want 1", dones); end
    if (a_fc !== 11'(a_fc_exp)) begin n_fail++; $display("FAIL bp_count got %0d want %0d", a_fc, a_fc_exp); end
  endtask

  task automatic test_overflow;
    logic [7:0] mq [$];
    logic [7:0] got [$];
    logic [7:0] ex [$];
    logic [7:0] v;
    int dones = 0;
    for (int j = 0; j < 130; j++) begin
      v = 8'($urandom);
      @(posedge clk); #1;
      a_pv = 1'b1; a_pd = v;
      if (j < 128) mq.push_back(v);
      @(negedge clk);
      if (j == 127) begin
        n_cmp++;
        if (a_pr !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_127 got %b want 1", a_pr); end
      end
      if (j >= 128) begin
        n_cmp++;
        if (a_pr !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_full%0d got %b want 0", j, a_pr); end
      end
    end
    @(posedge clk); #1;
    a_pv = 1'b0; a_txr = 1'b1; a_enable = 1'b1;
    for (int c = 0; c < 330; c++) begin
      @(negedge clk);
      if (a_txv && a_txr) got.push_back(a_txd);
      if (a_done) dones++;
    end
    @(posedge clk); #1 a_enable = 1'b0;
    for (int f = 0; f < 32; f++) begin
      ex.push_back(8'hEB); ex.push_back(8'h90);
      for (int i = 0; i < 4; i++) ex.push_back(mq[4*f+i]);
      ex.push_back(8'h90); ex.push_back(8'hEB);
    end
    a_fc_exp += 32;
    n_cmp += 3;
    if (got.size() != ex.size()) begin n_fail++; $display("FAIL ovf_len got %0d want %0d", got.size(), ex.size()); end
    if (dones != 32) begin n_fail++; $display("FAIL ovf_dones got %0d want 32", dones); end
    if (a_fc !== 11'(a_fc_exp)) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", a_fc, a_fc_exp); end
    for (int i = 0; i < got.size() && i < ex.size(); i++) begin
      n_cmp++;
      if (got[i] !== ex[i]) begin n_fail++; $display("FAIL ovf_byte%0d got %h want %h", i, got[i], ex[i]); end
    end
  endtask

  task automatic test_random;
    logic [7:0] mq [$];
    logic [7:0] got [$];
    logic [7:0] ex [$];
    int dones = 0, frames;
    logic held = 1'b0;
    logic [7:0] held_d = '0;
    a_enable = 1'b1;
    for (int c = 0; c < 620; c++) begin
      @(posedge clk); #1;
      if (c < 300) begin
        a_pv  = ($urandom % 3 == 0);
        a_pd  = 8'($urandom);
        a_txr = ($urandom % 4 != 0);
      end else begin
        a_pv  = 1'b0;
        a_txr = 1'b1;
      end
      @(negedge clk);
      if (a_pv && a_pr) mq.push_back(a_pd);
      if (held) begin
        n_cmp++;
        if ({a_txv, a_txd} !== {1'b1, held_d}) begin
          n_fail++;
          $display("FAIL rnd_stable got valid=%b data=%h want valid=1 data=%h", a_txv, a_txd, held_d);
        end
      end
      held   = a_txv && !a_txr;
      held_d = a_txd;
      if (a_txv && a_txr) got.push_back(a_txd);
      if (a_done) dones++;
    end
    @(posedge clk); #1 a_enable = 1'b0;
    frames = mq.size() / 4;
    for (int f = 0; f < frames; f++) begin
      ex.push_back(8'hEB); ex.push_back(8'h90);
      for (int i = 0; i < 4; i++) ex.push_back(mq[4*f+i]);
      ex.push_back(8'h90); ex.push_back(8'hEB);
    end
    a_fc_exp += frames;
    n_cmp += 3;
    if (got.size() != ex.size()) begin n_fail++; $display("FAIL rnd_len got %0d want %0d", got.size(), ex.size()); end
    if (dones != frames) begin n_fail++; $display("FAIL rnd_dones got %0d want %0d", dones, frames); end
    if (a_fc !== 11'(a_fc_exp)) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", a_fc, a_fc_exp); end
    for (int i = 0; i < got.size() && i < ex.size(); i++) begin
      n_cmp++;
      if (got[i] !== ex[i]) begin n_fail++; $display("FAIL rnd_byte%0d got %h want %h", i, got[i], ex[i]); end
    end
  endtask

  task automatic test_sub;
    logic [7:0]  got [$];
    logic [7:0]  ex [$];
    logic [15:0] sets [2] = '{16'hAABB, 16'hCCDD};
    logic [7:0]  base [2] = '{8'h10, 8'h20};
    logic        loaded = 1'b0;
    int          dones = 0;
    @(posedge clk); #1 b_sdv = 1'b1; b_sd = 16'hAABB;
    @(posedge clk); #1 b_sdv = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 6; i++) push_b(base[f] + 8'(i));
    @(posedge clk); #1;
    b_pv = 1'b0; b_txr = 1'b1; b_enable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (got.size() >= 4 && !loaded) begin
        b_sdv = 1'b1; b_sd = 16'hCCDD; loaded = 1'b1;
      end else begin
        b_sdv = 1'b0;
      end
      @(negedge clk);
      if (b_txv && b_txr) got.push_back(b_txd);
      if (b_done) begin
        dones++;
        n_cmp++;
        if (b_txv !== 1'b0) begin n_fail++; $display("FAIL sub_gap got valid=%b want 0", b_txv); end
      end
    end
    @(posedge clk); #1 b_enable = 1'b0;
    for (int f = 0; f < 2; f++) begin
      ex.push_back(8'hEB); ex.push_back(8'h90);
      for (int i = 0; i < 6; i++) begin
        if (i >= 2 && i < 4) ex.push_back(sets[f][15-8*(i-2) -: 8]);
        else                 ex.push_back(base[f] + 8'(i));
      end
      ex.push_back(8'h90); ex.push_back(8'hEB);
    end
    n_cmp += 3;
    if (got.size() != ex.size()) begin n_fail++; $display("FAIL sub_len got %0d want %0d", got.size(), ex.size()); end
    if (dones != 2) begin n_fail++; $display("FAIL sub_dones got %0d want 2", dones); end
    if (b_fc !== 11'd2) begin n_fail++; $display("FAIL sub_count got %0d want 2", b_fc); end
    for (int i = 0; i < got.size() && i < ex.size(); i++) begin
      n_cmp++;
      if (got[i] !== ex[i]) begin n_fail++; $display("FAIL sub_byte%0d got %h want %h", i, got[i], ex[i]); end
    end
  endtask

  task automatic test_reset_midframe;
    int got = 0, waited = 0, seen_v = 0, seen_d = 0;
    for (int i = 0; i < 6; i++) push_b(8'h30 + 8'(i));
    @(posedge clk); #1;
    b_pv = 1'b0; b_txr = 1'b1; b_enable = 1'b1;
    while (got < 4 && waited < 30) begin
      @(negedge clk);
      if (b_txv && b_txr) got++;
      waited++;
    end
    n_cmp++;
    if (got != 4) begin n_fail++; $display("FAIL rstm_reach got %0d want 4", got); end
    @(posedge clk); #2;
    n_cmp++;
    if ({b_txv, b_txd} !== {1'b1, 8'hCC}) begin
      n_fail++; $display("FAIL rstm_p2 got valid=%b data=%h want valid=1 data=cc", b_txv, b_txd);
    end
    resetn = 1'b0;
    #1;
    n_cmp += 7;
    if (b_txv !== 1'b0)  begin n_fail++; $display("FAIL rstm_valid got %b want 0", b_txv); end
    if (b_busy !== 1'b0) begin n_fail++; $display("FAIL rstm_busy got %b want 0", b_busy); end
    if (b_done !== 1'b0) begin n_fail++; $display("FAIL rstm_done got %b want 0", b_done); end
    if (b_fc !== 11'd0)  begin n_fail++; $display("FAIL rstm_count got %0d want 0", b_fc); end
    if (b_pr !== 1'b1)   begin n_fail++; $display("FAIL rstm_ready got %b want 1", b_pr); end
    if (u_b.u_fifo.empty !== 1'b1) begin n_fail++; $display("FAIL rstm_fifo_empty got %b want 1", u_b.u_fifo.empty); end
    if (a_fc !== 11'd0)  begin n_fail++; $display("FAIL rstm_a_count got %0d want 0", a_fc); end
    @(posedge clk); #1 resetn = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (b_txv)  seen_v++;
      if (b_done) seen_d++;
    end
    b_enable = 1'b0;
    n_cmp += 3;
    if (seen_v != 0) begin n_fail++; $display("FAIL rstm_no_restart got %0d want 0", seen_v); end
    if (seen_d != 0) begin n_fail++; $display("FAIL rstm_no_done got %0d want 0", seen_d); end
    if (b_fc !== 11'd0) begin n_fail++; $display("FAIL rstm_count_after got %0d want 0", b_fc); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; a_fc_exp = 0;
    resetn = 1'b1;
    a_enable = 1'b0; a_pv = 1'b0; a_pd = '0; a_sdv = 1'b0; a_sd = '0; a_txr = 1'b0;
    b_enable = 1'b0; b_pv = 1'b0; b_pd = '0; b_sdv = 1'b0; b_sd = '0; b_txr = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_overflow;
    test_random;
    test_sub;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
